// File: rtl/fifo_tx_sched_if.sv
// FIFO read-side and UART TX handshake bundle for fifo_tx_sched.
// The master modport is the scheduler. The slave modport is the FIFO/UART side.
interface fifo_tx_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic                  tx_busy;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;

    modport master (
        input  empty, rdata, tx_busy,
        output rinc, tx_data, tx_valid
    );

    modport slave (
        output empty, rdata, tx_busy,
        input  rinc, tx_data, tx_valid
    );
endinterface

// File: rtl/fifo_tx_sched.sv
// Pops one FIFO word at a time and offers it to the UART TX; optional inter-frame gap (FIFO_TX_SCHED_GAP_EN).
// Latency: tx_valid rises RD_LAT+1 cycles after the rinc pulse; IDLE-to-IDLE is at least 4+RD_LAT cycles plus UART busy time.
// Backpressure: holds the word on tx_valid until tx_busy is seen, then waits for tx_busy to drop before the next pop.
module fifo_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1,
    parameter int CNT_W      = 16,
    parameter int GAP_W      = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             enable,
    fifo_tx_sched_if.master  bus,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic [CNT_W-1:0] frames_sent,
    output logic             idle
);

`ifdef FIFO_TX_SCHED_GAP_EN
    typedef enum logic [2:0] {IDLE, POP, RD_WAIT, OFFER, SENDING, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, POP, RD_WAIT, OFFER, SENDING} state_t;
`endif

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t                state;
    state_t                state_nxt;
    logic [1:0]            lat_cnt;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [CNT_W-1:0]      frames_q;
    logic                  capture;
    logic                  frame_done;

`ifdef FIFO_TX_SCHED_GAP_EN
    logic [GAP_W-1:0]      gap_cnt;

    // Gap length is latched as the frame completes; later gap_cycles changes do not matter.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            gap_cnt <= '0;
        end else if (frame_done) begin
            gap_cnt <= gap_cycles;
        end else if (state == GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end
`else
    logic unused_gap;
    assign unused_gap = ^gap_cycles;
`endif

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            tx_data_q <= '0;
            frames_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == POP) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == RD_WAIT && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (capture) begin
                tx_data_q <= bus.rdata;
            end
            if (frame_done) begin
                frames_q <= frames_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !bus.empty && !bus.tx_busy) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    capture   = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (bus.tx_busy) begin
                    state_nxt = SENDING;
                end
            end
            SENDING: begin
                if (!bus.tx_busy) begin
                    frame_done = 1'b1;
`ifdef FIFO_TX_SCHED_GAP_EN
                    state_nxt  = (gap_cycles != '0) ? GAP : IDLE;
`else
                    state_nxt  = IDLE;
`endif
                end
            end
`ifdef FIFO_TX_SCHED_GAP_EN
            GAP: begin
                // The counter holds the number of gap cycles still to go, this one included.
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rinc     = (state == POP);
    assign bus.tx_valid = (state == OFFER);
    assign bus.tx_data  = tx_data_q;
    assign frames_sent  = frames_q;
    assign idle         = (state == IDLE);

endmodule

// File: tb/tb_fifo_tx_sched.sv
// Bench for fifo_tx_sched: a FIFO/UART environment, a timestamp-based reference model checked every cycle,
// and directed literal checks for reset, latency, burst, enable drop, counter wrap and gap length.
module tb_fifo_tx_sched;
    localparam int RD_LAT = 1;
    localparam int CNT_W  = 4;
    localparam int DW     = 8;
`ifdef FIFO_TX_SCHED_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic             rclk = 1'b0;
    logic             rrst = 1'b1;
    logic             enable = 1'b0;
    logic [7:0]       gap_cycles = 8'd0;
    logic [CNT_W-1:0] frames_sent;
    logic             idle;

    fifo_tx_sched_if #(.DATA_WIDTH(DW)) bus ();

    fifo_tx_sched #(.DATA_WIDTH(DW), .RD_LAT(RD_LAT), .CNT_W(CNT_W), .GAP_W(8)) dut (
        .rclk        (rclk),
        .rrst        (rrst),
        .enable      (enable),
        .bus         (bus),
        .gap_cycles  (gap_cycles),
        .frames_sent (frames_sent),
        .idle        (idle)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit cmp_en = 1'b0;

    // environment: FIFO contents, read-data delay line, UART busy BFM
    logic [7:0] fq[$];
    logic [7:0] rd_word = 8'd0;
    int  rd_cyc = -10;
    bit  bfm_mute = 1'b0, bfm_rand = 1'b0, armed = 1'b0;
    int  bfm_dly = 0, bfm_len = 10, hold_left = 0, wait_left = 0, cur_len = 0;

    // reference model: frame timeline as timestamps
    bit  m_fly = 1'b0, m_acc = 1'b0;
    int  m_pop = -100, m_gap = 0, m_frames = 0;
    logic [7:0] m_word = 8'd0, m_data = 8'd0;

    // per-cycle samples and monitor
    logic s_rinc, s_valid, s_idle, s_rrst, s_enable, s_empty, s_busy;
    logic [7:0] s_data, s_gap;
    logic [CNT_W-1:0] s_frames, p_frames;
    bit  p_valid = 1'b0, p_busy = 1'b0;
    int  n_rinc = 0, n_fchg = 0, rinc_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    int  brise_cyc = 0, bfall_cyc = 0, fchg_cyc = 0;
    logic [7:0] rise_data = 8'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fq.push_back(w);
        bus.empty = 1'b0;
    endtask

    task automatic step();
        int dly, len;
        @(negedge rclk);
        s_rinc = bus.rinc;   s_valid = bus.tx_valid; s_data = bus.tx_data;
        s_idle = idle;       s_frames = frames_sent; s_rrst = rrst;
        s_enable = enable;   s_empty = bus.empty;    s_busy = bus.tx_busy; s_gap = gap_cycles;
        if (cmp_en) begin
            check("idle", s_idle, !m_fly && m_gap == 0);
            check("rinc", s_rinc, m_fly && cyc == m_pop);
            check("tx_valid", s_valid, m_fly && !m_acc && cyc >= m_pop + 1 + RD_LAT);
            check("tx_data", s_data, m_data);
            check("frames_sent", s_frames, m_frames % (1 << CNT_W));
        end
        if (s_rinc === 1'b1) begin n_rinc++; rinc_cyc = cyc; end
        if (s_valid === 1'b1 && !p_valid) begin rise_cyc = cyc; rise_data = s_data; end
        if (s_valid !== 1'b1 && p_valid) fall_cyc = cyc;
        if (s_busy && !p_busy) brise_cyc = cyc;
        if (!s_busy && p_busy) bfall_cyc = cyc;
        if (s_frames !== p_frames) begin n_fchg++; fchg_cyc = cyc; end
        p_valid = (s_valid === 1'b1); p_busy = s_busy; p_frames = s_frames;

        @(posedge rclk);
        // model
        if (s_rrst) begin
            m_fly = 1'b0; m_acc = 1'b0; m_gap = 0; m_frames = 0; m_data = 8'd0; m_pop = -100;
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (!m_fly) begin
            if (s_enable && !s_empty && !s_busy && fq.size() > 0) begin
                m_fly = 1'b1; m_acc = 1'b0; m_pop = cyc + 1; m_word = fq[0];
            end
        end else begin
            if (cyc == m_pop + RD_LAT) m_data = m_word;
            if (!m_acc) begin
                if (cyc >= m_pop + 1 + RD_LAT && s_busy) m_acc = 1'b1;
            end else if (!s_busy) begin
                m_frames++; m_fly = 1'b0; m_gap = GAP_ON ? int'(s_gap) : 0;
            end
        end
        // FIFO
        if (s_rinc === 1'b1) begin
            check("pop_while_empty", s_empty, 1'b0);
            if (fq.size() > 0) begin rd_word = fq.pop_front(); rd_cyc = cyc + RD_LAT; end
        end
        // UART BFM; in random mode it sometimes raises busy before tx_valid appears
        if (s_rrst) begin
            hold_left = 0; armed = 1'b0;
        end else if (hold_left > 0) begin
            hold_left--;
        end else if (armed) begin
            wait_left--;
            if (wait_left <= 0) begin hold_left = cur_len; armed = 1'b0; end
        end else if (!bfm_mute && (s_valid === 1'b1 ||
                     (bfm_rand && s_rinc === 1'b1 && $urandom_range(0, 3) == 0))) begin
            dly = bfm_rand ? int'($urandom_range(0, 3)) : bfm_dly;
            len = bfm_rand ? int'($urandom_range(1, 8)) : bfm_len;
            if (dly == 0) hold_left = len;
            else begin armed = 1'b1; wait_left = dly; cur_len = len; end
        end
        cyc++;
        #1;
        bus.tx_busy = (hold_left > 0);
        bus.empty   = (fq.size() == 0);
        bus.rdata   = (cyc == rd_cyc) ? rd_word : 8'($urandom);
    endtask

    initial begin
        int n0, f0, c0, n;
        bus.empty = 1'b1; bus.rdata = 8'd0; bus.tx_busy = 1'b0;

        // reset state
        step(); cmp_en = 1'b1; step();
        check("rst_idle", s_idle, 1'b1);
        check("rst_rinc", s_rinc, 1'b0);
        check("rst_valid", s_valid, 1'b0);
        check("rst_data", s_data, 8'h00);
        check("rst_frames", s_frames, 4'd0);
        rrst = 1'b0;

        // single frame, fixed 10-cycle busy
        n0 = n_rinc; bfm_dly = 0; bfm_len = 10;
        push(8'h3C); enable = 1'b1;
        for (int i = 0; i < 60 && s_frames !== 4'd1; i++) step();
        check("single_frames", s_frames, 4'd1);
        check("single_pops", n_rinc - n0, 1);
        check("single_valid_lat", rise_cyc - rinc_cyc, 2);
        check("single_data", rise_data, 8'h3C);
        check("single_busy_len", bfall_cyc - brise_cyc, 10);
        check("single_valid_fall", fall_cyc - brise_cyc, 1);
        check("single_count_after_busy", fchg_cyc - bfall_cyc, 1);

        // burst of three then empty
        n0 = n_rinc; f0 = int'(s_frames); bfm_rand = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        repeat (150) step();
        check("burst_pops", n_rinc - n0, 3);
        check("burst_frames", s_frames, (f0 + 3) % 16);
        check("burst_idle", s_idle, 1'b1);

        // enable dropped mid-frame
        n0 = n_rinc; f0 = int'(s_frames); bfm_rand = 1'b0; bfm_dly = 1; bfm_len = 6;
        push(8'h44); push(8'h55);
        for (int i = 0; i < 40 && !s_busy; i++) step();
        check("drop_reach_sending", s_busy, 1'b1);
        enable = 1'b0;
        repeat (60) step();
        check("drop_pops", n_rinc - n0, 1);
        check("drop_frames", s_frames, (f0 + 1) % 16);
        check("drop_idle", s_idle, 1'b1);
        enable = 1'b1;
        repeat (40) step();
        check("drop_resume_pops", n_rinc - n0, 2);

        // inter-frame gap, including a gap_cycles change mid-gap
        bfm_dly = 0; bfm_len = 3; gap_cycles = 8'd5; f0 = int'(s_frames);
        push(8'h66);
        for (int i = 0; i < 40 && int'(s_frames) == f0; i++) step();
        n = 0;
        while (!s_idle && n < 20) begin n++; step(); gap_cycles = 8'd1; end
        check("gap5_len", n, GAP_ON ? 5 : 0);
        gap_cycles = 8'd0; f0 = int'(s_frames);
        push(8'h77);
        for (int i = 0; i < 40 && int'(s_frames) == f0; i++) step();
        n = 0;
        while (!s_idle && n < 20) begin n++; step(); end
        check("gap0_len", n, 0);

        // reset while offering A5
        bfm_mute = 1'b1; push(8'hA5);
        for (int i = 0; i < 20 && s_valid !== 1'b1; i++) step();
        check("offer_reached", s_valid, 1'b1);
        check("offer_data", s_data, 8'hA5);
        enable = 1'b0; rrst = 1'b1; step(); step(); rrst = 1'b0; step();
        check("midrst_valid", s_valid, 1'b0);
        check("midrst_data", s_data, 8'h00);
        check("midrst_frames", s_frames, 4'd0);
        check("midrst_idle", s_idle, 1'b1);
        check("midrst_rinc", s_rinc, 1'b0);
        bfm_mute = 1'b0;

        // 17 frames wrap a 4-bit counter to 1
        bfm_len = 1; c0 = n_fchg; enable = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i + 8'h80));
        for (int i = 0; i < 600 && n_fchg - c0 < 17; i++) step();
        check("wrap_count", n_fchg - c0, 17);
        check("wrap_frames", s_frames, 4'd1);

        // randomized traffic
        bfm_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 6) push(8'($urandom));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) gap_cycles = 8'($urandom_range(0, 4));
            rrst = ($urandom_range(0, 999) == 0);
            step();
        end
        rrst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
